// File: rtl/ccc_clken_gen_if.sv
// Control/status bundle of the fabric clock-enable generator.
// Signal suffixes are from the generator's point of view.
interface ccc_clken_gen_if #(
    parameter int NUM_CH = 3,
    parameter int DIV_W  = 5,
    parameter int DLY_W  = 5
) ();
    localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic              resync_i;
    logic [NUM_CH-1:0] ch_en_i;
    logic              cfg_we_i;
    logic [SEL_W-1:0]  cfg_sel_i;
    logic [DIV_W-1:0]  cfg_div_i;
    logic [DLY_W-1:0]  cfg_dly_i;
    logic [NUM_CH-1:0] ce_o;
    logic              lock_o;
    logic [NUM_CH-1:0] pending_o;

    modport slave (
        input  resync_i, ch_en_i, cfg_we_i, cfg_sel_i, cfg_div_i, cfg_dly_i,
        output ce_o, lock_o, pending_o
    );

    modport master (
        output resync_i, ch_en_i, cfg_we_i, cfg_sel_i, cfg_div_i, cfg_dly_i,
        input  ce_o, lock_o, pending_o
    );
endinterface

// File: rtl/ccc_clken_gen.sv
// Fabric clock-enable generator: NUM_CH programmable CE pulse trains with per-channel
// divide and phase delay, aligned by a settle/lock sequencer that RESYNC can restart.
module ccc_clken_gen #(
    parameter int NUM_CH      = 3,
    parameter int DIV_W       = 5,
    parameter int DLY_W       = 5,
    parameter int DEF_DIV     = 3,
    parameter int LOCK_CYCLES = 64
) (
    input  logic           clk,
    input  logic           rst_n,
    ccc_clken_gen_if.slave bus
);
    localparam int LCNT_W = $clog2(LOCK_CYCLES);
    localparam logic [LCNT_W-1:0] LCNT_LAST = LCNT_W'(LOCK_CYCLES - 1);
    localparam logic [DIV_W-1:0]  DIV_RST   = DIV_W'(DEF_DIV);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PHASE = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;

    logic [LCNT_W-1:0] lcnt_q, lcnt_d;
    logic              lock_q, lock_d;
    logic              lock_set;

    logic [NUM_CH-1:0][1:0]       state_q, state_d;
    logic [NUM_CH-1:0][DIV_W-1:0] pcnt_q, pcnt_d;
    logic [NUM_CH-1:0][DIV_W-1:0] div_act_q, div_act_d;
    logic [NUM_CH-1:0][DIV_W-1:0] div_sh_q, div_sh_d;
    logic [NUM_CH-1:0][DLY_W-1:0] dcnt_q, dcnt_d;
    logic [NUM_CH-1:0][DLY_W-1:0] dly_act_q, dly_act_d;
    logic [NUM_CH-1:0][DLY_W-1:0] dly_sh_q, dly_sh_d;
    logic [NUM_CH-1:0]            ce_q, ce_d;
    logic [NUM_CH-1:0]            pending_q, pending_d;
    logic [NUM_CH-1:0]            fire, promote, wr;

    // The counter freezes once locked; the LOCK-setting edge doubles as a start edge.
    always_comb begin
        lcnt_d   = lcnt_q;
        lock_d   = lock_q;
        lock_set = !lock_q && (lcnt_q == LCNT_LAST);
        if (bus.resync_i) begin
            lcnt_d = '0;
            lock_d = 1'b0;
        end else if (!lock_q) begin
            if (lock_set) begin
                lock_d = 1'b1;
            end else begin
                lcnt_d = lcnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        pcnt_d    = pcnt_q;
        dcnt_d    = dcnt_q;
        div_act_d = div_act_q;
        dly_act_d = dly_act_q;
        div_sh_d  = div_sh_q;
        dly_sh_d  = dly_sh_q;
        pending_d = pending_q;
        ce_d      = '0;
        fire      = '0;
        promote   = '0;
        wr        = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (bus.resync_i || !bus.ch_en_i[i]) begin
                state_d[i] = ST_IDLE;
            end else begin
                case (state_q[i])
                    ST_IDLE: begin
                        if (lock_q || lock_set) begin
                            if (dly_act_q[i] == '0) begin
                                state_d[i] = ST_RUN;
                                fire[i]    = 1'b1;
                            end else begin
                                state_d[i] = ST_PHASE;
                                dcnt_d[i]  = dly_act_q[i] - 1'b1;
                            end
                        end
                    end
                    // Down-counter so a DLY promoted mid-phase cannot disturb this start.
                    ST_PHASE: begin
                        if (dcnt_q[i] == '0) begin
                            state_d[i] = ST_RUN;
                            fire[i]    = 1'b1;
                        end else begin
                            dcnt_d[i] = dcnt_q[i] - 1'b1;
                        end
                    end
                    ST_RUN: begin
                        if (pcnt_q[i] == div_act_q[i]) begin
                            fire[i] = 1'b1;
                        end else begin
                            pcnt_d[i] = pcnt_q[i] + 1'b1;
                        end
                    end
                    default: state_d[i] = ST_IDLE;
                endcase
            end

            if (fire[i]) begin
                ce_d[i]   = 1'b1;
                pcnt_d[i] = '0;
            end

            // Promote only on a CE edge while running so no period is cut or stretched.
            promote[i] = pending_q[i] && !bus.resync_i && (fire[i] || state_q[i] != ST_RUN);
            if (promote[i]) begin
                div_act_d[i] = div_sh_q[i];
                dly_act_d[i] = dly_sh_q[i];
                pending_d[i] = 1'b0;
            end

            wr[i] = bus.cfg_we_i && (int'(bus.cfg_sel_i) == i);
            if (wr[i]) begin
                div_sh_d[i]  = bus.cfg_div_i;
                dly_sh_d[i]  = bus.cfg_dly_i;
                pending_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lcnt_q    <= '0;
            lock_q    <= 1'b0;
            state_q   <= {NUM_CH{ST_IDLE}};
            pcnt_q    <= '0;
            dcnt_q    <= '0;
            div_act_q <= {NUM_CH{DIV_RST}};
            div_sh_q  <= {NUM_CH{DIV_RST}};
            dly_act_q <= '0;
            dly_sh_q  <= '0;
            ce_q      <= '0;
            pending_q <= '0;
        end else begin
            lcnt_q    <= lcnt_d;
            lock_q    <= lock_d;
            state_q   <= state_d;
            pcnt_q    <= pcnt_d;
            dcnt_q    <= dcnt_d;
            div_act_q <= div_act_d;
            div_sh_q  <= div_sh_d;
            dly_act_q <= dly_act_d;
            dly_sh_q  <= dly_sh_d;
            ce_q      <= ce_d;
            pending_q <= pending_d;
        end
    end

    assign bus.ce_o      = ce_q;
    assign bus.lock_o    = lock_q;
    assign bus.pending_o = pending_q;
endmodule

// File: tb/tb_ccc_clken_gen.sv
// Directed bench for ccc_clken_gen: lock timing, phase/divide programming,
// glitch-free divide change, resync, channel enable toggling and async reset.
module tb_ccc_clken_gen;
    localparam int NUM_CH      = 3;
    localparam int DIV_W       = 5;
    localparam int DLY_W       = 5;
    localparam int DEF_DIV     = 3;
    localparam int LOCK_CYCLES = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    ccc_clken_gen_if #(.NUM_CH(NUM_CH), .DIV_W(DIV_W), .DLY_W(DLY_W)) bus ();

    ccc_clken_gen #(
        .NUM_CH(NUM_CH), .DIV_W(DIV_W), .DLY_W(DLY_W),
        .DEF_DIV(DEF_DIV), .LOCK_CYCLES(LOCK_CYCLES)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Outputs are sampled and inputs driven 1 time unit after each rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        bus.resync_i = 1'b0;
        bus.cfg_we_i = 1'b0;
        bus.cfg_sel_i = '0;
        bus.cfg_div_i = '0;
        bus.cfg_dly_i = '0;
        bus.ch_en_i = '1;
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.resync_i = 1'b0;
        bus.ch_en_i = '0;
        bus.cfg_we_i = 1'b0;
        bus.cfg_sel_i = '0;
        bus.cfg_div_i = '0;
        bus.cfg_dly_i = '0;
        #3;
        checks++;
        if (bus.ce_o !== 3'b000) begin
            errors++;
            $display("[TB] FAIL reset_ce: got %b expected 000", bus.ce_o);
        end
        checks++;
        if (bus.lock_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_lock: got %b expected 0", bus.lock_o);
        end
        checks++;
        if (bus.pending_o !== 3'b000) begin
            errors++;
            $display("[TB] FAIL reset_pending: got %b expected 000", bus.pending_o);
        end
    endtask

    task automatic test_lock_default();
        reset_dut();
        for (int k = 1; k <= 63; k++) begin
            step();
            checks++;
            if ({bus.lock_o, bus.ce_o} !== 4'b0000) begin
                errors++;
                $display("[TB] FAIL settle_edge%0d: got lock/ce %b expected 0000", k, {bus.lock_o, bus.ce_o});
            end
        end
        step();
        checks++;
        if ({bus.lock_o, bus.ce_o} !== 4'b1111) begin
            errors++;
            $display("[TB] FAIL lock_edge64: got lock/ce %b expected 1111", {bus.lock_o, bus.ce_o});
        end
        for (int k = 1; k <= 4; k++) begin
            logic [2:0] exp_ce;
            exp_ce = (k == 4) ? 3'b111 : 3'b000;
            step();
            checks++;
            if (bus.ce_o !== exp_ce) begin
                errors++;
                $display("[TB] FAIL div4_default+%0d: got %b expected %b", k, bus.ce_o, exp_ce);
            end
        end
    endtask

    task automatic test_phase_fast();
        logic [2:0] exp_t [4];
        exp_t = '{3'b000, 3'b010, 3'b010, 3'b111};
        reset_dut();
        bus.cfg_we_i = 1'b1;
        bus.cfg_sel_i = 2'd1;
        bus.cfg_div_i = 5'd0;
        bus.cfg_dly_i = 5'd2;
        step();
        bus.cfg_we_i = 1'b0;
        checks++;
        if (bus.pending_o !== 3'b010) begin
            errors++;
            $display("[TB] FAIL pending_set_ch1: got %b expected 010", bus.pending_o);
        end
        step();
        checks++;
        if (bus.pending_o !== 3'b000) begin
            errors++;
            $display("[TB] FAIL pending_clear_idle: got %b expected 000", bus.pending_o);
        end
        for (int k = 3; k <= 63; k++) step();
        step();
        checks++;
        if ({bus.lock_o, bus.ce_o} !== 4'b1101) begin
            errors++;
            $display("[TB] FAIL phase_lock_edge: got lock/ce %b expected 1101", {bus.lock_o, bus.ce_o});
        end
        for (int k = 0; k < 4; k++) begin
            step();
            checks++;
            if (bus.ce_o !== exp_t[k]) begin
                errors++;
                $display("[TB] FAIL phase_lock+%0d: got %b expected %b", k + 1, bus.ce_o, exp_t[k]);
            end
        end
    endtask

    task automatic test_div_change();
        step();
        bus.cfg_we_i = 1'b1;
        bus.cfg_sel_i = 2'd0;
        bus.cfg_div_i = 5'd7;
        bus.cfg_dly_i = 5'd0;
        step();
        bus.cfg_we_i = 1'b0;
        checks++;
        if (bus.pending_o !== 3'b001) begin
            errors++;
            $display("[TB] FAIL pending_set_ch0: got %b expected 001", bus.pending_o);
        end
        step();
        checks++;
        if ({bus.pending_o[0], bus.ce_o[0]} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL midperiod_hold: got pend0/ce0 %b expected 10", {bus.pending_o[0], bus.ce_o[0]});
        end
        step();
        checks++;
        if ({bus.pending_o[0], bus.ce_o[0]} !== 2'b01) begin
            errors++;
            $display("[TB] FAIL promote_on_ce: got pend0/ce0 %b expected 01", {bus.pending_o[0], bus.ce_o[0]});
        end
        for (int k = 1; k <= 8; k++) begin
            logic exp_b;
            exp_b = (k == 8);
            step();
            checks++;
            if (bus.ce_o[0] !== exp_b) begin
                errors++;
                $display("[TB] FAIL div8_ce0+%0d: got %b expected %b", k, bus.ce_o[0], exp_b);
            end
        end
    endtask

    task automatic test_resync();
        logic [2:0] exp_t [9];
        exp_t = '{3'b101, 3'b000, 3'b010, 3'b010, 3'b110, 3'b010, 3'b010, 3'b010, 3'b111};
        bus.resync_i = 1'b1;
        step();
        bus.resync_i = 1'b0;
        checks++;
        if ({bus.lock_o, bus.ce_o} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL resync_edge: got lock/ce %b expected 0000", {bus.lock_o, bus.ce_o});
        end
        for (int k = 1; k <= 63; k++) step();
        checks++;
        if ({bus.lock_o, bus.ce_o} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL resync_settle63: got lock/ce %b expected 0000", {bus.lock_o, bus.ce_o});
        end
        for (int k = 0; k < 9; k++) begin
            step();
            checks++;
            if ({bus.lock_o, bus.ce_o} !== {1'b1, exp_t[k]}) begin
                errors++;
                $display("[TB] FAIL resync_relock+%0d: got lock/ce %b expected %b", k, {bus.lock_o, bus.ce_o}, {1'b1, exp_t[k]});
            end
        end
    endtask

    task automatic test_chen_toggle();
        bus.ch_en_i = 3'b011;
        bus.cfg_we_i = 1'b1;
        bus.cfg_sel_i = 2'd2;
        bus.cfg_div_i = 5'd3;
        bus.cfg_dly_i = 5'd1;
        step();
        bus.cfg_we_i = 1'b0;
        checks++;
        if ({bus.pending_o, bus.ce_o[2]} !== 4'b1000) begin
            errors++;
            $display("[TB] FAIL chen_low1: got pend/ce2 %b expected 1000", {bus.pending_o, bus.ce_o[2]});
        end
        step();
        checks++;
        if ({bus.pending_o, bus.ce_o[2]} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL chen_low2: got pend/ce2 %b expected 0000", {bus.pending_o, bus.ce_o[2]});
        end
        step();
        checks++;
        if (bus.ce_o[2] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL chen_low3: got %b expected 0", bus.ce_o[2]);
        end
        bus.ch_en_i = 3'b111;
        for (int k = 4; k <= 9; k++) begin
            logic exp_b;
            exp_b = (k == 5) || (k == 9);
            step();
            checks++;
            if (bus.ce_o[2] !== exp_b) begin
                errors++;
                $display("[TB] FAIL chen_reenable_edge%0d: got %b expected %b", k, bus.ce_o[2], exp_b);
            end
        end
    endtask

    task automatic test_async_reset_oor();
        logic [2:0] exp_t [4];
        exp_t = '{3'b000, 3'b000, 3'b000, 3'b111};
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.lock_o, bus.ce_o, bus.pending_o} !== 7'b0) begin
            errors++;
            $display("[TB] FAIL async_reset: got lock/ce/pend %b expected 0000000", {bus.lock_o, bus.ce_o, bus.pending_o});
        end
        step();
        rst_n = 1'b1;
        bus.cfg_we_i = 1'b1;
        bus.cfg_sel_i = 2'd3;
        bus.cfg_div_i = 5'd0;
        bus.cfg_dly_i = 5'd5;
        step();
        bus.cfg_we_i = 1'b0;
        checks++;
        if (bus.pending_o !== 3'b000) begin
            errors++;
            $display("[TB] FAIL oor_write_pending: got %b expected 000", bus.pending_o);
        end
        for (int k = 2; k <= 63; k++) step();
        step();
        checks++;
        if ({bus.lock_o, bus.ce_o} !== 4'b1111) begin
            errors++;
            $display("[TB] FAIL oor_lock_edge: got lock/ce %b expected 1111", {bus.lock_o, bus.ce_o});
        end
        for (int k = 0; k < 4; k++) begin
            step();
            checks++;
            if (bus.ce_o !== exp_t[k]) begin
                errors++;
                $display("[TB] FAIL oor_period+%0d: got %b expected %b", k + 1, bus.ce_o, exp_t[k]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_lock_default();
        test_phase_fast();
        test_div_change();
        test_resync();
        test_chen_toggle();
        test_async_reset_oor();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
